// File: rtl/ps_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps_ctrl_pkg
//   Shared types and opcode constants for the program_sequencer control
//   front end (ps_jump_ctrl and its instruction decoder).
// ---------------------------------------------------------------------------
package ps_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALT     = 2'd2
  } ps_state_t;

  localparam logic [3:0] OP_JMP     = 4'hE;  // unconditional jump, low nibble = page
  localparam logic [3:0] OP_JNZ     = 4'hD;  // jump if zero flag clear
  localparam logic [7:0] INSTR_NOP  = 8'h00;
  localparam logic [7:0] INSTR_HALT = 8'h0F;

endpackage

// File: rtl/ps_jump_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps_jump_ctrl_if
//   Signal bundle between ps_jump_ctrl and its environment
//   (program ROM, ALU flag source, program_sequencer).
//   slave  : the controller (consumes pm_data/ALU flags, drives sequencer ctrl)
//   master : the environment side
// ---------------------------------------------------------------------------
interface ps_jump_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       pm_data;       // instruction byte at pm_addr
  logic             alu_zero;      // ALU result is zero
  logic             alu_zero_vld;  // alu_zero carries a flag update this cycle
  logic             ext_halt;      // external halt request (level)
  logic             sync_reset;    // program_sequencer sync reset
  logic             jmp;           // unconditional jump
  logic             jmp_nz;        // jump if not zero
  logic             dont_jmp;      // effective zero flag
  logic [3:0]       jmp_addr;      // target page, pm_addr = {jmp_addr,4'h0}
  logic [7:0]       ir;            // instruction register
  logic             halted;        // parked in HALT
  logic [CNT_W-1:0] taken_cnt;     // saturating taken-branch count

  modport slave (
    input  pm_data, alu_zero, alu_zero_vld, ext_halt,
    output sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, ir, halted, taken_cnt
  );

  modport master (
    output pm_data, alu_zero, alu_zero_vld, ext_halt,
    input  sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, ir, halted, taken_cnt
  );
endinterface

// File: rtl/ps_instr_decode.sv
// ---------------------------------------------------------------------------
// ps_instr_decode
//   Pure combinational decode of the instruction register.
//   i_ir      : instruction byte
//   o_is_jmp  : ir[7:4] == OP_JMP
//   o_is_jnz  : ir[7:4] == OP_JNZ
//   o_is_halt : ir == INSTR_HALT
//   o_addr    : branch target page (ir[3:0])
// ---------------------------------------------------------------------------
module ps_instr_decode
  import ps_ctrl_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic       o_is_jmp,
  output logic       o_is_jnz,
  output logic       o_is_halt,
  output logic [3:0] o_addr
);
  assign o_is_jmp  = (i_ir[7:4] == OP_JMP);
  assign o_is_jnz  = (i_ir[7:4] == OP_JNZ);
  assign o_is_halt = (i_ir == INSTR_HALT);
  assign o_addr    = i_ir[3:0];
endmodule

// File: rtl/ps_jump_ctrl.sv
// ---------------------------------------------------------------------------
// ps_jump_ctrl
//   Control front end for program_sequencer: holds sync_reset after power-up,
//   decodes the fetched byte into jmp / jmp_nz / dont_jmp / jmp_addr, tracks
//   the ALU zero flag, squashes the one in-flight fetch after a taken branch,
//   parks the core on HALT and counts taken branches.
//   clk     : rising-edge clock
//   reset_n : async active-low reset
//   bus     : ps_jump_ctrl_if.slave (ROM byte, ALU flag, halt in; sequencer
//             controls, ir, halted, taken_cnt out)
// ---------------------------------------------------------------------------
module ps_jump_ctrl
  import ps_ctrl_pkg::*;
#(
  parameter int         RST_CYCLES = 2,      // 1..15
  parameter logic [3:0] HALT_PAGE  = 4'hF,
  parameter int         CNT_W      = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  ps_jump_ctrl_if.slave  bus
);

  ps_state_t        r_state, w_state_nxt;
  logic [3:0]       r_rst_cnt;
  logic             r_z_flag;
  logic             r_flush;
  logic [7:0]       r_ir;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_is_jmp, w_is_jnz, w_is_halt;
  logic [3:0]       w_addr;
  logic             w_dont_jmp, w_br_en, w_taken;

  ps_instr_decode u_dec (
    .i_ir      (r_ir),
    .o_is_jmp  (w_is_jmp),
    .o_is_jnz  (w_is_jnz),
    .o_is_halt (w_is_halt),
    .o_addr    (w_addr)
  );

  // Same-cycle bypass so a flag update can steer the branch it arrives with.
  assign w_dont_jmp = bus.alu_zero_vld ? bus.alu_zero : r_z_flag;
  // ext_halt overrides any branch decoded in the same cycle.
  assign w_br_en    = (r_state == RUN) && !bus.ext_halt && !r_flush;
  assign w_taken    = w_br_en && (w_is_jmp || (w_is_jnz && !w_dont_jmp));

  always_comb begin
    w_state_nxt    = r_state;
    bus.sync_reset = 1'b0;
    bus.jmp        = 1'b0;
    bus.jmp_nz     = 1'b0;
    bus.jmp_addr   = 4'h0;
    bus.halted     = 1'b0;
    case (r_state)
      RST_HOLD: begin
        bus.sync_reset = 1'b1;
        if (r_rst_cnt == 4'(RST_CYCLES - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        bus.jmp    = w_br_en && w_is_jmp;
        bus.jmp_nz = w_br_en && w_is_jnz;
        if (w_br_en && (w_is_jmp || w_is_jnz)) bus.jmp_addr = w_addr;
        if (bus.ext_halt || w_is_halt) w_state_nxt = HALT;
      end
      HALT: begin
        // Re-issue the park jump every cycle so pm_addr stays on HALT_PAGE.
        bus.jmp      = 1'b1;
        bus.jmp_addr = HALT_PAGE;
        bus.halted   = 1'b1;
      end
      default: w_state_nxt = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RST_HOLD;
      r_rst_cnt   <= 4'd0;
      r_z_flag    <= 1'b0;
      r_flush     <= 1'b0;
      r_ir        <= INSTR_NOP;
      r_taken_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RST_HOLD) r_rst_cnt <= r_rst_cnt + 4'd1;
      if (bus.alu_zero_vld) r_z_flag <= bus.alu_zero;
      // The byte arriving on the taken edge is the sequential fetch from the
      // branch cycle; it is dropped right there so the target byte lands in ir
      // two edges after the branch. r_flush marks that squashed NOP slot.
      r_flush <= w_taken;
      if (r_state == RUN && w_state_nxt == RUN && !w_taken) r_ir <= bus.pm_data;
      else                                                  r_ir <= INSTR_NOP;
      if (w_taken && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign bus.dont_jmp  = w_dont_jmp;
  assign bus.ir        = r_ir;
  assign bus.taken_cnt = r_taken_cnt;

endmodule
